// File: rtl/fetch_stage.sv
// fetch_stage: PC register, instruction ROM read and IF/ID pipeline register with stall/redirect and perf counters.
module fetch_imem #(
  parameter int WORDS = 1024
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(WORDS)-1:0] waddr,
  input  logic [31:0]              wdata,
  input  logic [$clog2(WORDS)-1:0] raddr,
  output logic [31:0]              rdata
);
  logic [31:0] mem_data [WORDS];
  always_ff @(posedge clk) if (we) mem_data[waddr] <= wdata;
  assign rdata = mem_data[raddr];
endmodule

module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          MEM_WORDS = 1024,
  parameter logic [31:0] NOP       = 32'h0000_0000,
  parameter int          CNT_W     = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             branch_taken,
  input  logic [31:0]      branch_target,
  output logic [31:0]      pc,
  output logic [31:0]      if_id_instr,
  output logic [31:0]      if_id_pc4,
  output logic             if_id_valid,
  output logic [CNT_W-1:0] fetch_count,
  output logic [CNT_W-1:0] stall_count
);
  localparam int AW = $clog2(MEM_WORDS);
  logic [31:0] rdata, fetched, pc4;
  fetch_imem #(.WORDS(MEM_WORDS)) instr_mem (
    .clk(clk), .we(1'b0), .waddr('0), .wdata('0),
    .raddr(pc[AW+1:2]), .rdata(rdata)
  );
  // Beyond the ROM the fetch returns a bubble instead of aliasing into low memory.
  assign fetched = (pc[31:2] < 30'(MEM_WORDS)) ? rdata : NOP;
  assign pc4 = pc + 32'd4;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      pc          <= RESET_PC;
      if_id_instr <= NOP;
      if_id_pc4   <= '0;
      if_id_valid <= 1'b0;
      fetch_count <= '0;
      stall_count <= '0;
    end else if (branch_taken) begin
      pc          <= branch_target & ~32'h3;
      if_id_instr <= NOP;
      if_id_pc4   <= '0;
      if_id_valid <= 1'b0;
    end else if (stall) begin
      stall_count <= stall_count + CNT_W'(stall_count != '1);
    end else begin
      pc          <= pc4;
      if_id_instr <= fetched;
      if_id_pc4   <= pc4;
      if_id_valid <= 1'b1;
      fetch_count <= fetch_count + CNT_W'(fetch_count != '1);
    end
endmodule
